// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, command bytes,
// default timing and the frame builder.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_STOP      = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6,
        ST_FAIL      = 3'd7
    } tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 100000;
    localparam int DEF_FILTER_LEN     = 8;

    // {stop, odd parity, data}; bit 0 goes out first.
    function automatic logic [9:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Two-flop synchroniser plus glitch filter: the level only moves after
// FILTER_LEN identical consecutive samples. Idle (released) level is 1.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o
);

    logic                  sync1_q, sync2_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic                  level_q, level_d;

    always_comb begin
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            level_q <= 1'b1;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[FILTER_LEN-2:0], sync2_q};
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, device-clocked
// bits, ACK check). Define PS2_TX_RETRY_EN to retry once after a NACK or timeout.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    tx_state_e   state_q, state_d;
    logic [9:0]  frame_q, frame_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] timer_q, timer_d;
    logic        data_q, data_d;
    logic        clk_prev_q;
    logic        clk_f, data_f;
    logic        fe, fe_live, timeout, bus_idle, fail_now;
`ifdef PS2_TX_RETRY_EN
    logic        retry_q, retry_d;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .line_i  (PS2_CLK_IN),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .line_i  (PS2_DATA_IN),
        .level_o (data_f)
    );

    assign fe       = clk_prev_q & ~clk_f;
    assign fe_live  = fe && (state_q inside {ST_SEND, ST_STOP, ST_ACK});
    assign bus_idle = clk_f & data_f;
    // The timer holds 1 in the first cycle after an entry or fe, so FAIL lands
    // exactly TIMEOUT_CYCLES after the last fe.
    assign timeout  = (state_q inside {ST_SEND, ST_STOP, ST_ACK, ST_WAIT_IDLE}) &&
                      (timer_q >= TIMEOUT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            data_q     <= 1'b1;
            clk_prev_q <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            clk_prev_q <= clk_f;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        fail_now  = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iSend) begin
                    frame_d = ps2_frame(iData);
                    state_d = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            ST_INHIBIT: begin
                if (timer_q >= INHIBIT_LAST) begin
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                state_d   = ST_SEND;
                bit_cnt_d = '0;
                data_d    = 1'b0;
            end
            ST_SEND: begin
                if (timeout) begin
                    fail_now = 1'b1;
                end else if (fe) begin
                    data_d    = frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (timeout) begin
                    fail_now = 1'b1;
                end else if (fe) begin
                    data_d  = frame_q[9];
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (timeout) begin
                    fail_now = 1'b1;
                end else if (fe) begin
                    if (!data_f) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        fail_now = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (timeout) begin
                    fail_now = 1'b1;
                end else if (bus_idle) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (fail_now) begin
            data_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                state_d = ST_INHIBIT;
                retry_d = 1'b1;
            end else begin
                state_d = ST_FAIL;
            end
`else
            state_d = ST_FAIL;
`endif
        end

        if (state_d == ST_IDLE) begin
            timer_d = '0;
        end else if ((state_d != state_q) || fe_live) begin
            timer_d = 32'd1;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_comb begin
        oPS2_CLK_OE  = 1'b0;
        oPS2_DATA_OE = 1'b0;
        oBusy        = (state_q != ST_IDLE);
        oDone        = 1'b0;
        oError       = 1'b0;
        case (state_q)
            ST_INHIBIT: begin
                oPS2_CLK_OE  = 1'b1;
                oPS2_DATA_OE = (timer_q >= INHIBIT_LAST);
            end
            ST_RTS:          oPS2_DATA_OE = 1'b1;
            ST_SEND, ST_STOP: oPS2_DATA_OE = ~data_q;
            ST_WAIT_IDLE:    oDone = !timeout && bus_idle;
            ST_FAIL:         oError = 1'b1;
            default: ;
        endcase
    end

endmodule
